// File: rtl/system_sequencer.sv
// rtl/system_sequencer.sv - run sequencer: idle/load/execute/halt control, RAM port arbitration, halt and timeout detection
module system_sequencer #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int HALT_CYCLES    = 5,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  loader_start,
  input  logic                  loader_done,
  input  logic                  loader_mem_write,
  input  logic [ADDR_WIDTH-1:0] loader_mem_addr,
  input  logic [DATA_WIDTH-1:0] loader_mem_write_data,
  input  logic                  cpu_mem_read,
  input  logic                  cpu_mem_write,
  input  logic [ADDR_WIDTH-1:0] cpu_mem_addr,
  input  logic [DATA_WIDTH-1:0] cpu_mem_write_data,
  input  logic [15:0]           cpu_pc,
  input  logic [2:0]            cpu_state,
  output logic                  cpu_hold,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic [1:0]            system_state,
  output logic                  halted,
  output logic                  timeout,
  output logic [31:0]           cycle_count
);

  localparam int SW = $clog2(HALT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LOADING   = 2'd1,
    S_EXECUTING = 2'd2,
    S_HALTED    = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_loader_start;
  logic            r_halted;
  logic            r_timeout;
  logic [31:0]     r_cycle_count;
  logic [15:0]     r_prev_pc;
  logic [SW-1:0]   r_stable_count;
  logic [SW-1:0]   w_stable_next;
  logic            w_pc_match;
  logic            w_halt_hit;
  logic            w_timeout_hit;
  logic            w_set_halted;
  logic            w_set_timeout;
  logic            w_enter_load;
  logic            w_enter_exec;

  // A fetch at the same PC as last cycle means the program is spinning on itself.
  always_comb begin
    w_pc_match    = (cpu_state == 3'd0) && (cpu_pc == r_prev_pc);
    w_stable_next = '0;
    if (w_pc_match) begin
      if (r_stable_count == {SW{1'b1}}) w_stable_next = r_stable_count;
      else                              w_stable_next = r_stable_count + 1'b1;
    end
    w_halt_hit    = (w_stable_next >= SW'(HALT_CYCLES));
    w_timeout_hit = (r_cycle_count == 32'(TIMEOUT_CYCLES - 1));
  end

  always_comb begin
    w_next        = r_state;
    w_set_halted  = 1'b0;
    w_set_timeout = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_next = S_LOADING;
      S_LOADING: if (loader_done) w_next = S_EXECUTING;
      S_EXECUTING: begin
        if (w_halt_hit) begin
          w_next       = S_HALTED;
          w_set_halted = 1'b1;
        end else if (w_timeout_hit) begin
          w_next        = S_HALTED;
          w_set_timeout = 1'b1;
        end
      end
      S_HALTED:  if (start) w_next = S_LOADING;
      default:   w_next = S_IDLE;
    endcase
  end

  assign w_enter_load = (w_next == S_LOADING) && (r_state != S_LOADING);
  assign w_enter_exec = (w_next == S_EXECUTING) && (r_state == S_LOADING);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_loader_start <= 1'b0;
      r_halted       <= 1'b0;
      r_timeout      <= 1'b0;
      r_cycle_count  <= 32'd0;
      r_stable_count <= '0;
      r_prev_pc      <= 16'hFFFF;
    end else begin
      r_state        <= w_next;
      r_loader_start <= w_enter_load;
      if (w_enter_load) begin
        r_halted       <= 1'b0;
        r_timeout      <= 1'b0;
        r_cycle_count  <= 32'd0;
        r_stable_count <= '0;
      end else if (w_enter_exec) begin
        r_prev_pc      <= 16'hFFFF;
        r_stable_count <= '0;
      end else if (r_state == S_EXECUTING) begin
        if (r_cycle_count != 32'hFFFF_FFFF) r_cycle_count <= r_cycle_count + 32'd1;
        r_stable_count <= w_stable_next;
        r_prev_pc      <= cpu_pc;
        if (w_set_halted)  r_halted  <= 1'b1;
        if (w_set_timeout) r_timeout <= 1'b1;
      end
    end
  end

  // RAM port owner follows the registered state only, so requests pass with no added latency.
  always_comb begin
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    case (r_state)
      S_LOADING: begin
        mem_write      = loader_mem_write;
        mem_addr       = loader_mem_addr;
        mem_write_data = loader_mem_write_data;
      end
      S_EXECUTING: begin
        mem_read       = cpu_mem_read;
        mem_write      = cpu_mem_write;
        mem_addr       = cpu_mem_addr;
        mem_write_data = cpu_mem_write_data;
      end
      default: ;
    endcase
  end

  assign cpu_hold     = (r_state != S_EXECUTING);
  assign loader_start = r_loader_start;
  assign system_state = r_state;
  assign halted       = r_halted;
  assign timeout      = r_timeout;
  assign cycle_count  = r_cycle_count;

endmodule

// File: doc/system_sequencer.md
# system_sequencer

Top-level controller for the binary 16-bit system. It sequences the system through idle, program loading, execution and halt, and shares the single RAM port between the program loader and the CPU. While executing, it detects a halted program (PC stable in fetch for `HALT_CYCLES` cycles) and enforces a cycle timeout. It sits between `loader`, `cpu` and `ram` inside `system`.

## Interface
- `ADDR_WIDTH`, 16: RAM address width.
- `DATA_WIDTH`, 16: RAM data width.
- `HALT_CYCLES`, 5: consecutive stable-PC fetch cycles that declare a halt; must be ≥1.
- `TIMEOUT_CYCLES`, 1000: maximum execution cycles before a forced halt; must be ≥1.

Ports:
- `clock` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: request to load and run the program; sampled on the clock edge.
- `loader_start` out 1: one-cycle pulse to the loader.
- `loader_done` in 1: loader finished; sampled only in LOADING.
- `loader_mem_write` in 1; `loader_mem_addr` in ADDR_WIDTH; `loader_mem_write_data` in DATA_WIDTH: loader RAM request.
- `cpu_mem_read` in 1; `cpu_mem_write` in 1; `cpu_mem_addr` in ADDR_WIDTH; `cpu_mem_write_data` in DATA_WIDTH: CPU RAM request.
- `cpu_pc` in 16: CPU program counter.
- `cpu_state` in 3: CPU FSM state; 0 is fetch.
- `cpu_hold` out 1: freezes the CPU when high.
- `mem_read` out 1; `mem_write` out 1; `mem_addr` out ADDR_WIDTH; `mem_write_data` out DATA_WIDTH: arbitrated RAM port.
- `system_state` out 2: IDLE=0, LOADING=1, EXECUTING=2, HALTED=3.
- `halted` out 1: execution ended by halt detection.
- `timeout` out 1: execution ended by timeout.
- `cycle_count` out 32: number of EXECUTING cycles in the current run.

## Operation
- **IDLE**
  - `start`=1 → LOADING.
  - `cpu_hold`=1; RAM port outputs all 0.
- **LOADING**
  - `loader_start`=1 in the first LOADING cycle only.
  - RAM port driven from the loader: `mem_read`=0, the other signals pass through.
  - `cpu_hold`=1.
  - `loader_done`=1 → EXECUTING.
- **EXECUTING**
  - `cpu_hold`=0; RAM port driven from the CPU.
  - `cycle_count` increments every cycle and saturates at 0xFFFFFFFF.
  - Halt detection:
    - `prev_pc` register holds the previous `cpu_pc`; it is loaded with 0xFFFF on entry to EXECUTING.
    - If `cpu_state`==0 and `cpu_pc`==`prev_pc`, `stable_count` increments; otherwise it clears to 0.
    - `stable_count` is $clog2(HALT_CYCLES+1) bits wide and saturates.
  - When the next `stable_count` reaches `HALT_CYCLES` → HALTED, `halted`=1.
  - When `cycle_count`==TIMEOUT_CYCLES-1 and no halt fires that cycle → HALTED, `timeout`=1.
  - If halt and timeout fire on the same cycle, the halt takes priority: `halted`=1, `timeout`=0.
- **HALTED**
  - `cpu_hold`=1; RAM port outputs all 0.
  - `halted`, `timeout` and `cycle_count` hold their values.
  - `start`=1 → LOADING, clearing `halted`, `timeout`, `cycle_count` and `stable_count`.
- `start` in LOADING or EXECUTING is ignored. `loader_done` outside LOADING is ignored.
- CPU memory requests outside EXECUTING and loader writes outside LOADING are dropped (not forwarded).

## Timing
- **Reset** (`reset`=0, asynchronous, any state, including mid-load or mid-run):
  - `system_state`=IDLE, `cpu_hold`=1.
  - `loader_start`, `mem_*`, `halted`, `timeout` = 0; `cycle_count`=0.
  - Internal: `stable_count`=0, `prev_pc`=0xFFFF.
  - Deassertion takes effect on the first rising edge after `reset` returns high.
- **State register:** all transitions are registered, one edge after the qualifying input is sampled high.
- **RAM mux:** combinational from the registered `system_state`; zero added latency on the RAM request path.
- **Start to load:**
  - `start` high at edge N → `system_state`=LOADING and `loader_start`=1 during cycle N+1.
  - `loader_start`=0 from cycle N+2.
- **Load to run:** `loader_done` high at edge M → EXECUTING from cycle M+1.
  - `cpu_hold` falls in the same cycle.
  - `cycle_count` reads 1 after the first EXECUTING edge.
- **Halt latency:** minimum HALT_CYCLES+1 EXECUTING cycles; the first cycle cannot match because `prev_pc` starts at 0xFFFF.
- **Timeout:** HALTED is entered after exactly TIMEOUT_CYCLES EXECUTING cycles; `cycle_count` then reads TIMEOUT_CYCLES.

## Test plan
- **Reset values:** `reset`=0 mid-EXECUTING with CPU writing addr 0x0010 → same cycle: `system_state`=0, `cpu_hold`=1, `mem_write`=0, `cycle_count`=0.
- **Start and load:** pulse `start`; loader writes 0x1234 to addr 0x0003; raise `loader_done` → `loader_start` is high for exactly one cycle; `mem_addr`=0x0003, `mem_write_data`=0x1234 during LOADING; EXECUTING next cycle; `cpu_hold`=0.
- **Halt detection:** in EXECUTING, hold `cpu_pc`=0x0007 with `cpu_state`=0 → HALTED after 6 cycles (HALT_CYCLES=5); `halted`=1, `timeout`=0. Repeat with `cpu_state`=2 on one of the cycles → the counter restarts.
- **Timeout:** TIMEOUT_CYCLES=20 with the PC incrementing every cycle → HALTED with `timeout`=1 and `cycle_count`=20; RAM outputs 0.
- **Simultaneous halt and timeout:** TIMEOUT_CYCLES=6, HALT_CYCLES=5, PC constant from entry → `halted`=1, `timeout`=0.
- **Ignored and repeated starts:** `start` during LOADING and EXECUTING has no effect; `start` in HALTED → LOADING, flags cleared, `cycle_count`=0, second run completes normally.
